// File: rtl/sobel_edge_3x3_8bit.sv
// 3x3 Sobel edge detector: |Gx|+|Gy| thresholded to a 1-bit edge map, 3-clock latency.
// Optional macro SOBEL_MAG_OUT_EN exposes the saturated magnitude on post_img_mag.
module sobel_edge_3x3_8bit #(
  parameter int          IMG_W  = 1024,
  parameter logic [7:0]  THRESH = 8'd40
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       pre_frame_vsync,
  input  logic       pre_frame_href,
  input  logic       pre_frame_clken,
  input  logic [7:0] pre_img_y,
  input  logic [7:0] row2_y,
  input  logic [7:0] row1_y,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic       post_img_bit,
  output logic [7:0] post_img_mag
);

  localparam logic [10:0] COL_MAX = 11'(IMG_W - 1);
  localparam logic [10:0] ROW_MAX = 11'h7FF;

  logic [7:0]  r_p11, r_p12, r_p13, r_p21, r_p22, r_p23, r_p31, r_p32, r_p33;
  logic [7:0]  w_n11, w_n12, w_n13, w_n21, w_n22, w_n23, w_n31, w_n32, w_n33;
  logic [10:0] r_col, r_row;
  logic        r_href_d, r_vsync_d;
  logic        w_win_ok;
  logic [10:0] w_gx_p, w_gx_n, w_gy_p, w_gy_n;
  logic [10:0] r_gx, r_gy;
  logic        r_v1, r_v2;
  logic [10:0] w_abs_gx, w_abs_gy;
  logic [10:0] r_sum;
  logic [7:0]  w_mag;
  logic        r_bit;
  logic [2:0]  r_sync_d1, r_sync_d2, r_sync_d3;

  // Stage 1 sees the window as it will be after this clken, so the
  // window register and the gradient register load on the same edge.
  always_comb begin
    w_n11 = r_p11; w_n12 = r_p12; w_n13 = r_p13;
    w_n21 = r_p21; w_n22 = r_p22; w_n23 = r_p23;
    w_n31 = r_p31; w_n32 = r_p32; w_n33 = r_p33;
    if (pre_frame_clken) begin
      w_n11 = r_p12; w_n12 = r_p13; w_n13 = row1_y;
      w_n21 = r_p22; w_n22 = r_p23; w_n23 = row2_y;
      w_n31 = r_p32; w_n32 = r_p33; w_n33 = pre_img_y;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_p11 <= '0; r_p12 <= '0; r_p13 <= '0;
      r_p21 <= '0; r_p22 <= '0; r_p23 <= '0;
      r_p31 <= '0; r_p32 <= '0; r_p33 <= '0;
    end else begin
      r_p11 <= w_n11; r_p12 <= w_n12; r_p13 <= w_n13;
      r_p21 <= w_n21; r_p22 <= w_n22; r_p23 <= w_n23;
      r_p31 <= w_n31; r_p32 <= w_n32; r_p33 <= w_n33;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_col     <= '0;
      r_row     <= '0;
      r_href_d  <= 1'b0;
      r_vsync_d <= 1'b0;
    end else begin
      r_href_d  <= pre_frame_href;
      r_vsync_d <= pre_frame_vsync;
      if (!pre_frame_href)
        r_col <= '0;
      else if (pre_frame_clken && (r_col != COL_MAX))
        r_col <= r_col + 11'd1;
      if (pre_frame_vsync && !r_vsync_d)
        r_row <= '0;
      else if (!pre_frame_href && r_href_d && (r_row != ROW_MAX))
        r_row <= r_row + 11'd1;
    end
  end

  // Counters hold the column/row index of the pixel arriving this cycle.
  assign w_win_ok = pre_frame_clken && (r_col >= 11'd2) && (r_row >= 11'd2);

  assign w_gx_p = {3'd0, w_n13} + {2'd0, w_n23, 1'b0} + {3'd0, w_n33};
  assign w_gx_n = {3'd0, w_n11} + {2'd0, w_n21, 1'b0} + {3'd0, w_n31};
  assign w_gy_p = {3'd0, w_n31} + {2'd0, w_n32, 1'b0} + {3'd0, w_n33};
  assign w_gy_n = {3'd0, w_n11} + {2'd0, w_n12, 1'b0} + {3'd0, w_n13};

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_gx <= '0;
      r_gy <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_gx <= w_gx_p - w_gx_n;
      r_gy <= w_gy_p - w_gy_n;
      r_v1 <= w_win_ok;
    end
  end

  // Gradients are two's complement in 11 bits; magnitudes stay below 1024.
  assign w_abs_gx = r_gx[10] ? (11'd0 - r_gx) : r_gx;
  assign w_abs_gy = r_gy[10] ? (11'd0 - r_gy) : r_gy;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
      r_v2  <= 1'b0;
    end else begin
      r_sum <= w_abs_gx + w_abs_gy;
      r_v2  <= r_v1;
    end
  end

  assign w_mag = (r_sum > 11'd255) ? 8'hFF : r_sum[7:0];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) r_bit <= 1'b0;
    else     r_bit <= r_v2 && (w_mag > THRESH);
  end

`ifdef SOBEL_MAG_OUT_EN
  logic [7:0] r_mag;
  always_ff @(posedge clock or posedge rst) begin
    if (rst) r_mag <= '0;
    else     r_mag <= r_v2 ? w_mag : 8'd0;
  end
  assign post_img_mag = r_mag;
`else
  assign post_img_mag = 8'd0;
`endif

  // Sync delay line: {vsync, href, clken}, independent of window validity.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_sync_d1 <= '0;
      r_sync_d2 <= '0;
      r_sync_d3 <= '0;
    end else begin
      r_sync_d1 <= {pre_frame_vsync, pre_frame_href, pre_frame_clken};
      r_sync_d2 <= r_sync_d1;
      r_sync_d3 <= r_sync_d2;
    end
  end

  assign post_frame_vsync = r_sync_d3[2];
  assign post_frame_href  = r_sync_d3[1];
  assign post_frame_clken = r_sync_d3[0];
  assign post_img_bit     = r_bit;

endmodule

// File: tb/tb_sobel_edge_3x3_8bit.sv
// Bench for sobel_edge_3x3_8bit: image-level Sobel reference model, expected queue,
// sync-delay and latency checks, clken gaps, mid-frame vsync and reset.
module tb_sobel_edge_3x3_8bit;

  localparam int         W  = 8;
  localparam logic [7:0] TH = 8'd40;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic       vs = 1'b0, hr = 1'b0, ck = 1'b0;
  logic [7:0] p3 = '0, p2 = '0, p1 = '0;
  logic       o_vs, o_hr, o_ck, o_bit;
  logic [7:0] o_mag;

  always #5 clock = ~clock;

  sobel_edge_3x3_8bit #(.IMG_W(W), .THRESH(TH)) dut (
    .clock(clock), .rst(rst),
    .pre_frame_vsync(vs), .pre_frame_href(hr), .pre_frame_clken(ck),
    .pre_img_y(p3), .row2_y(p2), .row1_y(p1),
    .post_frame_vsync(o_vs), .post_frame_href(o_hr), .post_frame_clken(o_ck),
    .post_img_bit(o_bit), .post_img_mag(o_mag)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [8:0] exp_q[$];   // {bit, mag}
  int         exp_t[$];   // clock edge that sampled the completing clken
  int         m_col, m_row;
  logic       m_href_prev, m_vsync_prev;
  int         c_top[3], c_mid[3], c_bot[3];   // last three columns, [2] newest
  logic [7:0] img[W][W];

  int         cyc = 0;
  int         rst_edge = 0;
  logic [2:0] in_log[8];

  task automatic model_reset();
    m_col = 0; m_row = 0; m_href_prev = 1'b0; m_vsync_prev = 1'b0;
    for (int i = 0; i < 3; i++) begin c_top[i] = 0; c_mid[i] = 0; c_bot[i] = 0; end
    exp_q.delete();
    exp_t.delete();
  endtask

  task automatic model_step();
    int gx, gy, s, mag;
    logic valid, b;
    if (ck) begin
      for (int i = 0; i < 2; i++) begin
        c_top[i] = c_top[i+1]; c_mid[i] = c_mid[i+1]; c_bot[i] = c_bot[i+1];
      end
      c_top[2] = p1; c_mid[2] = p2; c_bot[2] = p3;
      valid = (m_col >= 2) && (m_row >= 2);
      gx = (c_top[2] + 2*c_mid[2] + c_bot[2]) - (c_top[0] + 2*c_mid[0] + c_bot[0]);
      gy = (c_bot[0] + 2*c_bot[1] + c_bot[2]) - (c_top[0] + 2*c_top[1] + c_top[2]);
      s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      mag = (s > 255) ? 255 : s;
      if (!valid) mag = 0;
      b = valid && (mag > int'(TH));
`ifndef SOBEL_MAG_OUT_EN
      mag = 0;
`endif
      exp_q.push_back({b, 8'(mag)});
      exp_t.push_back(cyc + 1);
    end
    if (!hr) m_col = 0;
    else if (ck && m_col < W - 1) m_col++;
    if (vs && !m_vsync_prev) m_row = 0;
    else if (!hr && m_href_prev && m_row < 2047) m_row++;
    m_href_prev = hr;
    m_vsync_prev = vs;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clock) begin
    cyc++;
    in_log[cyc % 8] = {vs, hr, ck};
    if (rst) rst_edge = cyc;
  end

  always @(negedge clock) begin
    if (!rst && (cyc - 2 > rst_edge)) begin
      check("sync_delay", {o_vs, o_hr, o_ck}, in_log[(cyc - 2) % 8]);
      if (o_ck) begin
        check("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          logic [8:0] e;
          int t;
          e = exp_q.pop_front();
          t = exp_t.pop_front();
          check("edge_bit", o_bit, e[8]);
          check("edge_mag", o_mag, e[7:0]);
          check("latency", cyc - t, 2);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic h, input logic c,
                       input logic [7:0] a3, input logic [7:0] a2, input logic [7:0] a1);
    vs = v; hr = h; ck = c; p3 = a3; p2 = a2; p1 = a1;
    model_step();
    @(posedge clock); #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    ck  = 1'b0;
    #1;
    check("rst_vsync", o_vs, 0);
    check("rst_href",  o_hr, 0);
    check("rst_clken", o_ck, 0);
    check("rst_bit",   o_bit, 0);
    check("rst_mag",   o_mag, 0);
    model_reset();
    @(posedge clock); #1;
    rst = 1'b0;
  endtask

  // mode 0 flat 100, 1 vertical step of lvl at column 4, 2 random
  task automatic frame(input int mode, input int lvl, input int gap_pct,
                       input int rst_r, input int rst_c, input int vs_r);
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++)
        case (mode)
          0:       img[r][c] = 8'd100;
          1:       img[r][c] = (c < 4) ? 8'd0 : 8'(lvl);
          default: img[r][c] = 8'($urandom_range(0, 255));
        endcase
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    for (int r = 0; r < W; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == rst_r && c == rst_c) reset_pulse();
        if (r == vs_r && c == 3) drive(1, 1, 0, 8'hAA, 8'h55, 8'hFF);
        while ($urandom_range(0, 99) < gap_pct)
          drive(0, 1, 0, 8'($urandom), 8'($urandom), 8'($urandom));
        drive(0, 1, 1, img[r][c],
              (r >= 1) ? img[r-1][c] : 8'd0,
              (r >= 2) ? img[r-2][c] : 8'd0);
      end
      for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 0, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("init_vsync", o_vs, 0);
    check("init_href",  o_hr, 0);
    check("init_clken", o_ck, 0);
    check("init_bit",   o_bit, 0);
    check("init_mag",   o_mag, 0);
    rst = 1'b0;
    repeat (2) drive(0, 0, 0, 0, 0, 0);

    frame(0, 0,   0,  -1, -1, -1);   // flat field
    frame(1, 200, 0,  -1, -1, -1);   // strong vertical step
    frame(1, 10,  0,  -1, -1, -1);   // weak step at threshold
    frame(1, 11,  0,  -1, -1, -1);   // weak step just above threshold
    frame(2, 0,   0,  -1, -1, -1);   // random image, border masking
    frame(2, 0,   0,  -1, -1, -1);   // second frame after another vsync
    frame(2, 0,   35, -1, -1, -1);   // clken gaps inside lines
    frame(1, 200, 25, -1, -1, 4);    // vsync pulse mid-line
    frame(2, 0,   20, 3,  4,  -1);   // async reset mid-line
    frame(1, 200, 10, -1, -1, -1);   // recovery frame

    repeat (6) drive(0, 0, 0, 0, 0, 0);
    check("drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sobel_edge_3x3_8bit.md
Name: sobel_edge_3x3_8bit

Overview:
Downstream consumer of the two-line 8-bit shift buffer in the HumanDetector path. Takes the current grey pixel plus the two buffered line taps and builds a 3x3 window. Computes the Sobel gradient |Gx|+|Gy| and thresholds it to a 1-bit edge map for the later morphology/projection stages. Re-times the frame sync signals so that post_* signals stay aligned with the result.

Parameters:
IMG_W, 1024, active pixels per line; sizes the column counter (11 bits max, matching the 2048-deep line RAM)
THRESH, 8'd40, edge threshold; edge = 1 when saturated magnitude > THRESH

Ports:
clock  in  1  pixel clock, single clock domain
rst  in  1  asynchronous, active-high reset
pre_frame_vsync  in  1  frame sync, high during frame blanking pulse
pre_frame_href  in  1  line valid
pre_frame_clken  in  1  pixel valid strobe
pre_img_y  in  8  current-line pixel (row 3, newest)
row2_y  in  8  previous-line pixel (taps0x), aligned with pre_img_y on same cycle
row1_y  in  8  line-before-previous pixel (taps1x), aligned with pre_img_y
post_frame_vsync  out  1  pre_frame_vsync delayed 3 cycles
post_frame_href  out  1  pre_frame_href delayed 3 cycles
post_frame_clken  out  1  pre_frame_clken delayed 3 cycles
post_img_bit  out  1  edge flag
post_img_mag  out  8  saturated gradient magnitude (see Optional Feature)

Behaviour:
- Reset (async, rst=1): all outputs 0; window regs, pipelines, counters and sync delay lines cleared. Deassertion is synchronous to clock through normal register update.
- Window (stage 0): on each cycle with pre_frame_clken=1, each row shifts left: P11<=P12<=P13<=row1_y; P21..P23 from row2_y; P31..P33 from pre_img_y. With clken=0 the window holds.
- col_cnt (11 bit):
  - increments on clken while href=1
  - cleared when href=0
  - saturates at IMG_W-1 and does not wrap
- row_cnt (11 bit):
  - increments on href falling edge
  - cleared on vsync rising edge
  - saturates at 2047
- Window valid = (col_cnt >= 2) && (row_cnt >= 2), sampled with the clken that completes the window. Invalid windows produce bit=0, mag=0.
- Stage 1: Gx = (P13+2*P23+P33) - (P11+2*P21+P31). Gy = (P31+2*P32+P33) - (P11+2*P12+P13). Both 11-bit signed, range ±1020. Valid flag pipelined alongside.
- Stage 2: sum = |Gx|+|Gy|, 11-bit unsigned, max 2040.
- Stage 3: mag = (sum > 255) ? 255 : sum[7:0]; post_img_bit = valid && (mag > THRESH).
- Latency: exactly 3 clocks from the pre_frame_clken that completes a window to post_frame_clken carrying its result. post_* sync signals are plain 3-stage delays, independent of valid.
- Stages 1–3 advance every clock (free-running pipeline). Results are only meaningful when post_frame_clken=1; outputs with clken=0 carry no meaning but must stay deterministic.
- vsync mid-line: row_cnt clears; the window contents are not flushed. Data is masked by valid until 2 new lines have arrived.
- href low mid-window: col_cnt clears; the first 2 pixels of each line are masked.
- Reset mid-frame: output is masked until the next 2 full lines after the first href rises.

Optional Feature:
SOBEL_MAG_OUT_EN
- Defined: post_img_mag drives the stage-3 saturated magnitude, registered and aligned with post_img_bit.
- Undefined: post_img_mag is tied to 8'd0 and the stage-3 magnitude register is removed. The internal compare uses the unregistered stage-2 saturation, so latency stays 3 and post_img_bit is bit-identical in both builds.

Test Plan:
- Flat field: all pixels 8'd100, 8x8 frame, IMG_W=8 -> post_img_bit=0 and mag=0 for every post_frame_clken.
- Vertical step: columns 0-3 = 0, columns 4-7 = 200 -> at the step, Gx=800, Gy=0, mag=255, bit=1; other columns bit=0.
- Weak edge: step of 10 levels (Gx=40) with THRESH=40 -> mag=40, bit=0. Step of 11 (Gx=44) -> mag=44, bit=1.
- Border masking: strong random image -> bit=0 and mag=0 for col<2 or row<2 of every frame, including after a second vsync pulse.
- Latency and clken gaps: clken toggling 1-0-1 inside lines -> each post_frame_clken occurs exactly 3 clocks after its pre_frame_clken, and the window holds across gaps so the result matches the gap-free reference.
- Async reset mid-line: rst pulse for 1 cycle mid-frame -> all outputs 0 within the same cycle; the next valid bit=1 appears only from row 2, col 2 after resumption.
